// File: rtl/sync_updown_counter.sv
// Synchronous up/down modulo counter with load, wrap/saturate and carry/borrow strobes.
// Ports: clk, rstn (async low), en, up, load, load_val -> out, tc, carry, borrow
// Optional gray_out port when SYNC_UPDOWN_GRAY_OUT_EN is defined.
module sync_updown_counter #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16,
  parameter int WRAP   = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef SYNC_UPDOWN_GRAY_OUT_EN
  output logic [WIDTH-1:0] gray_out,
`endif
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             carry,
  output logic             borrow
);

  // Top count kept in WIDTH bits; MODULO itself may not fit.
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] nxt;
  logic             nxt_carry;
  logic             nxt_borrow;

  always_comb begin
    nxt        = out;
    nxt_carry  = 1'b0;
    nxt_borrow = 1'b0;
    unique case (1'b1)
      load: begin
        // load_val > MAX is the same test as load_val >= MODULO
        nxt = (load_val > MAX) ? MAX : load_val;
      end
      (!load && en && up): begin
        if (out == MAX) begin
          nxt       = (WRAP != 0) ? '0 : MAX;
          nxt_carry = 1'b1;
        end else begin
          nxt = out + 1'b1;
        end
      end
      (!load && en && !up): begin
        if (out == '0) begin
          nxt        = (WRAP != 0) ? MAX : '0;
          nxt_borrow = 1'b1;
        end else begin
          nxt = out - 1'b1;
        end
      end
      default: begin
        nxt = out;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out    <= '0;
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else begin
      out    <= nxt;
      carry  <= nxt_carry;
      borrow <= nxt_borrow;
    end
  end

`ifdef SYNC_UPDOWN_GRAY_OUT_EN
  // Encoded from the next value so gray_out lines up with out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gray_out <= '0;
    end else begin
      gray_out <= nxt ^ (nxt >> 1);
    end
  end
`endif

  assign tc = up ? (out == MAX) : (out == '0);

endmodule

// File: tb/tb_sync_updown_counter.sv
// Randomized and directed bench for sync_updown_counter.
// Three instances: M10 wrap, M10 saturate, M16 wrap.
module tb_sync_updown_counter;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] q0, q1, q2;
  logic [3:0] g0, g1, g2;
  logic       t0, t1, t2;
  logic       c0, c1, c2;
  logic       b0, b1, b2;

  int vectors = 0;
  int miscompares = 0;

  int mod[3]  = '{10, 10, 16};
  int wrap[3] = '{1, 0, 1};
  int cnt[3];
  int cf[3];
  int bf[3];

  always #5 clk = ~clk;

  sync_updown_counter #(.WIDTH(4), .MODULO(10), .WRAP(1)) u0 (
    .clk(clk), .rstn(rstn), .en(en), .up(up),
    .load(load), .load_val(load_val),
`ifdef SYNC_UPDOWN_GRAY_OUT_EN
    .gray_out(g0),
`endif
    .out(q0), .tc(t0), .carry(c0), .borrow(b0)
  );

  sync_updown_counter #(.WIDTH(4), .MODULO(10), .WRAP(0)) u1 (
    .clk(clk), .rstn(rstn), .en(en), .up(up),
    .load(load), .load_val(load_val),
`ifdef SYNC_UPDOWN_GRAY_OUT_EN
    .gray_out(g1),
`endif
    .out(q1), .tc(t1), .carry(c1), .borrow(b1)
  );

  sync_updown_counter #(.WIDTH(4), .MODULO(16), .WRAP(1)) u2 (
    .clk(clk), .rstn(rstn), .en(en), .up(up),
    .load(load), .load_val(load_val),
`ifdef SYNC_UPDOWN_GRAY_OUT_EN
    .gray_out(g2),
`endif
    .out(q2), .tc(t2), .carry(c2), .borrow(b2)
  );

`ifndef SYNC_UPDOWN_GRAY_OUT_EN
  assign g0 = '0;
  assign g1 = '0;
  assign g2 = '0;
`endif

  task automatic chk(string tag, int got, int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0;
      cf[i]  = 0;
      bf[i]  = 0;
    end
  endtask

  // Count as plain integers on 0..mod-1.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int m;
      m = mod[i];
      cf[i] = 0;
      bf[i] = 0;
      if (load) begin
        cnt[i] = (int'(load_val) >= m) ? m - 1 : int'(load_val);
      end else if (en && up) begin
        if (cnt[i] + 1 >= m) begin
          cf[i]  = 1;
          cnt[i] = (wrap[i] != 0) ? (cnt[i] + 1) % m : m - 1;
        end else begin
          cnt[i] = cnt[i] + 1;
        end
      end else if (en && !up) begin
        if (cnt[i] - 1 < 0) begin
          bf[i]  = 1;
          cnt[i] = (wrap[i] != 0) ? cnt[i] - 1 + m : 0;
        end else begin
          cnt[i] = cnt[i] - 1;
        end
      end
    end
  endtask

  function automatic int exp_tc(int i);
    if (up) return (cnt[i] == mod[i] - 1) ? 1 : 0;
    return (cnt[i] == 0) ? 1 : 0;
  endfunction

  function automatic int gray(int v);
    return v ^ (v >> 1);
  endfunction

  task automatic check_one(int i, logic [3:0] o, logic t,
                           logic c, logic b, logic [3:0] g);
    string s;
    s = $sformatf("u%0d", i);
    chk({s, ".out"}, int'(o), cnt[i]);
    chk({s, ".tc"}, int'(t), exp_tc(i));
    chk({s, ".carry"}, int'(c), cf[i]);
    chk({s, ".borrow"}, int'(b), bf[i]);
    chk({s, ".cb_excl"}, int'(c & b), 0);
`ifdef SYNC_UPDOWN_GRAY_OUT_EN
    chk({s, ".gray"}, int'(g), gray(cnt[i]));
`else
    if (g != '0) chk({s, ".gray_tie"}, int'(g), 0);
`endif
  endtask

  task automatic check_all();
    check_one(0, q0, t0, c0, b0, g0);
    check_one(1, q1, t1, c1, b1, g1);
    check_one(2, q2, t2, c2, b2, g2);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(logic l, int lv, logic e, logic u);
    load     = l;
    load_val = 4'(lv);
    en       = e;
    up       = u;
    #1;
    check_all();
  endtask

  logic [3:0] prev_g;

  initial begin
    model_reset();
    #1;
    check_all();
    chk("rst.out", int'(q2), 0);
    chk("rst.tc_down", int'(t2), 1);
    #2 rstn = 1'b1;

    // up wrap at M10
    drive(1, 8, 0, 0);
    tick();
    drive(0, 0, 1, 1);
    tick();
    chk("wrap.out9", int'(q0), 9);
    chk("wrap.tc9", int'(t0), 1);
    chk("wrap.c_lo", int'(c0), 0);
    tick();
    chk("wrap.out0", int'(q0), 0);
    chk("wrap.c_hi", int'(c0), 1);
    tick();
    chk("wrap.out1", int'(q0), 1);
    chk("wrap.c_end", int'(c0), 0);

    // down saturate at M10
    drive(1, 1, 0, 0);
    tick();
    drive(0, 0, 1, 0);
    tick();
    chk("sat.b1", int'(b1), 0);
    chk("sat.tc", int'(t1), 1);
    tick();
    chk("sat.b2", int'(b1), 1);
    tick();
    chk("sat.b3", int'(b1), 1);
    chk("sat.out", int'(q1), 0);

    // load priority and clamp
    drive(1, 14, 1, 1);
    tick();
    chk("clamp.out", int'(q0), 9);
    chk("clamp.c", int'(c0), 0);
    chk("noclamp.out", int'(q2), 14);

    // direction flip on M16
    drive(1, 3, 0, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, (k % 2) == 0);
      tick();
      chk("flip.out", int'(q2), (k % 2 == 0) ? 4 : 3);
      chk("flip.tc", int'(t2), 0);
    end

`ifdef SYNC_UPDOWN_GRAY_OUT_EN
    drive(1, 0, 0, 0);
    tick();
    drive(0, 0, 1, 1);
    prev_g = g2;
    for (int k = 0; k < 17; k++) begin
      tick();
      chk("gray.step", $countones(g2 ^ prev_g), 1);
      prev_g = g2;
    end
`endif

    // asynchronous reset mid-count
    drive(1, 0, 0, 0);
    tick();
    drive(0, 0, 1, 1);
    for (int k = 0; k < 5; k++) tick();
    chk("mid.out5", int'(q2), 5);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("mid.rst", int'(q2), 0);
    #2 rstn = 1'b1;
    tick();
    chk("mid.resume", int'(q2), 1);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 15),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
